// File: rtl/decode_pkg.sv
// decode_pkg
// Shared definitions for the RV32I decode stage:
//   - base opcode constants for the supported instruction classes
//   - fmt_e, the instruction format tag carried with every decoded entry
//   - decoded_t, the decoded instruction record (also the FIFO entry type)
//   - DECODED_RESET, the all-zero entry with fmt=NONE used at reset
package decode_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd6
    } fmt_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        fmt_e        fmt;
        logic        illegal;
    } decoded_t;

    localparam decoded_t DECODED_RESET = '{
        pc:      32'd0,
        opcode:  7'd0,
        rd:      5'd0,
        rs1:     5'd0,
        rs2:     5'd0,
        funct3:  3'd0,
        funct7:  7'd0,
        imm:     32'd0,
        fmt:     FMT_NONE,
        illegal: 1'b0
    };

endpackage

// File: rtl/rv32_decode_comb.sv
// rv32_decode_comb
// Purely combinational RV32I decoder: raw instruction + pc -> decoded_t.
// Performs field extraction, immediate generation and the legality check.
// Ports:
//   pc    in  [31:0]  program counter, passed through unchanged
//   instr in  [31:0]  raw instruction word
//   dec   out decoded_t  decoded record
// Parameter ZERO_UNUSED: 1 = fields the format does not use read as 0,
// 0 = those fields carry the raw instruction bits.
module rv32_decode_comb
    import decode_pkg::*;
#(
    parameter int ZERO_UNUSED = 1
) (
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    output decoded_t    dec
);

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm_i;
    logic [31:0] imm_sh;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    logic        use_rd;
    logic        use_rs1;
    logic        use_rs2;
    logic        use_f3;
    logic        use_f7;
    logic        illegal;
    logic [31:0] imm;
    fmt_e        fmt;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_sh = {27'd0, instr[24:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'd0};
    assign imm_j  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    // Classify the opcode: pick the format, which register/funct fields the
    // format actually uses, the immediate, and whether the encoding is one of
    // the RV32I ops this stage supports. Shift immediates (funct3 001/101)
    // carry shamt in the rs2 slot and a funct7 qualifier, so they get their
    // own immediate and legality rules.
    always_comb begin
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_f3  = 1'b0;
        use_f7  = 1'b0;
        illegal = 1'b0;
        imm     = 32'd0;
        fmt     = FMT_NONE;
        case (opcode)
            OP: begin
                fmt     = FMT_R;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_f3  = 1'b1;
                use_f7  = 1'b1;
                if (funct7 == 7'b0100000) begin
                    illegal = !(funct3 == 3'b000 || funct3 == 3'b101);
                end else begin
                    illegal = (funct7 != 7'b0000000);
                end
            end
            OP_IMM: begin
                fmt     = FMT_I;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_f3  = 1'b1;
                use_f7  = 1'b1;
                if (funct3 == 3'b001) begin
                    imm     = imm_sh;
                    illegal = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    imm     = imm_sh;
                    illegal = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
                end else begin
                    imm     = imm_i;
                end
            end
            LOAD: begin
                fmt     = FMT_I;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_f3  = 1'b1;
                imm     = imm_i;
                illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            JALR: begin
                fmt     = FMT_I;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_f3  = 1'b1;
                imm     = imm_i;
                illegal = (funct3 != 3'b000);
            end
            STORE: begin
                fmt     = FMT_S;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_f3  = 1'b1;
                imm     = imm_s;
                illegal = (funct3 > 3'b010);
            end
            BRANCH: begin
                fmt     = FMT_B;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_f3  = 1'b1;
                imm     = imm_b;
                illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            LUI, AUIPC: begin
                fmt    = FMT_U;
                use_rd = 1'b1;
                imm    = imm_u;
            end
            JAL: begin
                fmt    = FMT_J;
                use_rd = 1'b1;
                imm    = imm_j;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    // Assemble the record. An illegal instruction keeps only its pc and raw
    // opcode so execute can still raise the exception at the right address;
    // everything else is cleared and the format is forced to NONE.
    always_comb begin
        dec         = DECODED_RESET;
        dec.pc      = pc;
        dec.opcode  = opcode;
        dec.illegal = illegal;
        if (!illegal) begin
            dec.rd     = (use_rd  || ZERO_UNUSED == 0) ? rd     : 5'd0;
            dec.rs1    = (use_rs1 || ZERO_UNUSED == 0) ? rs1    : 5'd0;
            dec.rs2    = (use_rs2 || ZERO_UNUSED == 0) ? rs2    : 5'd0;
            dec.funct3 = (use_f3  || ZERO_UNUSED == 0) ? funct3 : 3'd0;
            dec.funct7 = (use_f7  || ZERO_UNUSED == 0) ? funct7 : 7'd0;
            dec.imm    = imm;
            dec.fmt    = fmt;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage
// Registered, elastic RV32I decode stage between fetch and execute.
// Instructions are decoded combinationally on the input side and written
// into a DEPTH-entry FIFO; the head entry drives the outputs directly, so
// there is no combinational path from input to output.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               fetch handshake
//   in_pc, in_instr                 instruction and its pc
//   flush                           drop all buffered entries and this cycle's input
//   out_valid/out_ready             execute handshake
//   out_pc .. out_illegal           decoded fields of the head entry
//   dec_count                       saturating count of accepted instructions
module decode_stage
    import decode_pkg::*;
#(
    parameter int DEPTH       = 2,
    parameter int CNT_W       = 32,
    parameter int ZERO_UNUSED = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [6:0]       out_opcode,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [31:0]      out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] dec_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    decoded_t        in_dec;
    decoded_t        head;
    decoded_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            push;
    logic            pop;

    rv32_decode_comb #(
        .ZERO_UNUSED(ZERO_UNUSED)
    ) u_decode (
        .pc   (in_pc),
        .instr(in_instr),
        .dec  (in_dec)
    );

    // Full blocks input even if execute is popping this cycle, so a write
    // never lands on the slot being read.
    assign in_ready  = (count != FULL_COUNT);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    // Entry storage. Entries are cleared at reset so the outputs read as a
    // zeroed record with fmt=NONE until the first instruction arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DECODED_RESET;
            end
        end else if (push) begin
            mem[wr_ptr] <= in_dec;
        end
    end

    // Read/write pointers wrap naturally at DEPTH (a power of two). Flush
    // rewinds both so the buffer restarts from slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy, one bit wider than the pointers so full and empty differ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Accepted-instruction counter. It tracks fetch acceptance, so flush
    // does not rewind it; it sticks at all ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_count <= '0;
        end else if (push && (dec_count != '1)) begin
            dec_count <= dec_count + 1'b1;
        end
    end

    assign head        = mem[rd_ptr];
    assign out_pc      = head.pc;
    assign out_opcode  = head.opcode;
    assign out_rd      = head.rd;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_funct3  = head.funct3;
    assign out_funct7  = head.funct7;
    assign out_imm     = head.imm;
    assign out_fmt     = head.fmt;
    assign out_illegal = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
// Self-checking bench for decode_stage. A queue-based reference model of
// the output buffer holds expected records produced by a rule-based decoder
// function written directly from the RV32I field/immediate/legality rules.
// Directed steps cover the listed scenarios, followed by a randomized phase.
module tb_decode_stage;

    localparam int DEPTH = 2;
    localparam int CW    = 4;

    localparam logic [6:0] C_OP     = 7'h33;
    localparam logic [6:0] C_IMM    = 7'h13;
    localparam logic [6:0] C_LOAD   = 7'h03;
    localparam logic [6:0] C_STORE  = 7'h23;
    localparam logic [6:0] C_BRANCH = 7'h63;
    localparam logic [6:0] C_JAL    = 7'h6f;
    localparam logic [6:0] C_JALR   = 7'h67;
    localparam logic [6:0] C_LUI    = 7'h37;
    localparam logic [6:0] C_AUIPC  = 7'h17;

    localparam logic [2:0] F_R = 3'd0;
    localparam logic [2:0] F_I = 3'd1;
    localparam logic [2:0] F_S = 3'd2;
    localparam logic [2:0] F_B = 3'd3;
    localparam logic [2:0] F_U = 3'd4;
    localparam logic [2:0] F_J = 3'd5;
    localparam logic [2:0] F_N = 3'd6;

    typedef struct {
        logic [31:0] pc;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_pc;
    logic [31:0]   in_instr;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [6:0]    out_opcode;
    logic [4:0]    out_rd;
    logic [4:0]    out_rs1;
    logic [4:0]    out_rs2;
    logic [2:0]    out_funct3;
    logic [6:0]    out_funct7;
    logic [31:0]   out_imm;
    logic [2:0]    out_fmt;
    logic          out_illegal;
    logic [CW-1:0] dec_count;

    exp_t          q[$];
    logic [CW-1:0] exp_cnt;
    int            errors;
    int            checks;
    logic [31:0]   pc_next;

    decode_stage #(
        .DEPTH(DEPTH),
        .CNT_W(CW),
        .ZERO_UNUSED(1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_instr   (in_instr),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_opcode (out_opcode),
        .out_rd     (out_rd),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_funct3 (out_funct3),
        .out_funct7 (out_funct7),
        .out_imm    (out_imm),
        .out_fmt    (out_fmt),
        .out_illegal(out_illegal),
        .dec_count  (dec_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rule-based decode: which fields each class keeps, its immediate
    // layout, and its legality, straight from the instruction-set rules.
    function automatic exp_t ref_decode(input logic [31:0] pc, input logic [31:0] ins);
        exp_t       e;
        logic       legal;
        logic [4:0] keep;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] imm;
        logic [2:0] fmt;
        opc   = ins[6:0];
        f3    = ins[14:12];
        f7    = ins[31:25];
        legal = 1'b1;
        keep  = 5'b00000;
        imm   = 32'd0;
        fmt   = F_N;
        case (opc)
            C_OP: begin
                fmt = F_R; keep = 5'b11111;
                legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            end
            C_IMM: begin
                fmt = F_I; keep = 5'b11111;
                if (f3 == 3'd1) begin
                    imm = 32'(ins[24:20]); legal = (f7 == 7'h00);
                end else if (f3 == 3'd5) begin
                    imm = 32'(ins[24:20]); legal = (f7 == 7'h00) || (f7 == 7'h20);
                end else begin
                    imm = 32'($signed(ins[31:20]));
                end
            end
            C_LOAD: begin
                fmt = F_I; keep = 5'b01011; imm = 32'($signed(ins[31:20]));
                legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
            end
            C_JALR: begin
                fmt = F_I; keep = 5'b01011; imm = 32'($signed(ins[31:20]));
                legal = (f3 == 3'd0);
            end
            C_STORE: begin
                fmt = F_S; keep = 5'b01110;
                imm = 32'($signed({ins[31:25], ins[11:7]}));
                legal = (f3 <= 3'd2);
            end
            C_BRANCH: begin
                fmt = F_B; keep = 5'b01110;
                imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
                legal = !(f3 == 3'd2 || f3 == 3'd3);
            end
            C_LUI, C_AUIPC: begin
                fmt = F_U; keep = 5'b00001; imm = ins & 32'hFFFF_F000;
            end
            C_JAL: begin
                fmt = F_J; keep = 5'b00001;
                imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            end
            default: legal = 1'b0;
        endcase
        e.pc  = pc;
        e.opc = opc;
        e.ill = !legal;
        if (legal) begin
            e.rd  = keep[0] ? ins[11:7]  : 5'd0;
            e.rs1 = keep[1] ? ins[19:15] : 5'd0;
            e.rs2 = keep[2] ? ins[24:20] : 5'd0;
            e.f3  = keep[3] ? f3         : 3'd0;
            e.f7  = keep[4] ? f7         : 7'd0;
            e.imm = imm;
            e.fmt = fmt;
        end else begin
            e.rd = 5'd0; e.rs1 = 5'd0; e.rs2 = 5'd0; e.f3 = 3'd0; e.f7 = 7'd0;
            e.imm = 32'd0; e.fmt = F_N;
        end
        return e;
    endfunction

    // Random instruction biased toward known opcodes and legal funct7 values.
    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: r[6:0] = C_OP;
            1: r[6:0] = C_IMM;
            2: r[6:0] = C_LOAD;
            3: r[6:0] = C_STORE;
            4: r[6:0] = C_BRANCH;
            5: r[6:0] = C_JAL;
            6: r[6:0] = C_JALR;
            7: r[6:0] = C_LUI;
            8: r[6:0] = C_AUIPC;
            default: r = r;
        endcase
        if ((r[6:0] == C_OP || r[6:0] == C_IMM) && $urandom_range(0, 3) != 0) begin
            r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against the model state (called at negedge).
    task automatic checkOutput();
        chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("dec_count", 64'(dec_count), 64'(exp_cnt));
        if (q.size() > 0) begin
            chk("out_pc", 64'(out_pc), 64'(q[0].pc));
            chk("out_imm", 64'(out_imm), 64'(q[0].imm));
            chk("out_fields",
                64'({out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7, out_fmt, out_illegal}),
                64'({q[0].opc, q[0].rd, q[0].rs1, q[0].rs2, q[0].f3, q[0].f7, q[0].fmt, q[0].ill}));
        end
    endtask

    // One clock cycle: drive inputs at negedge, advance the model at the
    // posedge, and check the resulting outputs at the next negedge.
    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                                 input logic ordy, input logic fl);
        logic acc;
        logic pop;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        acc = v && (q.size() < DEPTH) && !fl;
        pop = (q.size() > 0) && ordy && !fl;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(ref_decode(pc, ins));
        end
        if (acc && exp_cnt != '1) exp_cnt++;
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        exp_cnt   = '0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        in_pc     = 32'd0;
        out_ready = 1'b0;
        flush     = 1'b0;

        // Power-on reset: empty buffer, zeroed record with fmt=NONE.
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_dec_count", 64'(dec_count), 64'd0);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        chk("rst_out_imm", 64'(out_imm), 64'd0);
        chk("rst_out_fmt", 64'(out_fmt), 64'(F_N));
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput();

        // ADDI x1,x0,5
        applyStimulus(1'b1, 32'h0050_0093, 32'h0000_0100, 1'b1, 1'b0);
        chk("addi_rd", 64'(out_rd), 64'd1);
        chk("addi_imm", 64'(out_imm), 64'h5);
        chk("addi_fmt", 64'(out_fmt), 64'(F_I));
        chk("addi_cnt", 64'(dec_count), 64'd1);

        // SW, JAL, LUI back to back with execute always ready.
        applyStimulus(1'b1, 32'h0020_A423, 32'h0000_0104, 1'b1, 1'b0);
        chk("sw_rs1_rs2_f3", 64'({out_rs1, out_rs2, out_funct3}), 64'({5'd1, 5'd2, 3'b010}));
        chk("sw_imm", 64'(out_imm), 64'd8);
        chk("sw_fmt", 64'(out_fmt), 64'(F_S));
        applyStimulus(1'b1, 32'hFFDF_F0EF, 32'h0000_0108, 1'b1, 1'b0);
        chk("jal_rd", 64'(out_rd), 64'd1);
        chk("jal_imm", 64'(out_imm), 64'hFFFF_FFFC);
        chk("jal_fmt", 64'(out_fmt), 64'(F_J));
        applyStimulus(1'b1, 32'h1234_52B7, 32'h0000_010C, 1'b1, 1'b0);
        chk("lui_rd", 64'(out_rd), 64'd5);
        chk("lui_imm", 64'(out_imm), 64'h1234_5000);
        chk("lui_fmt", 64'(out_fmt), 64'(F_U));

        // Illegal encodings keep their pc and raw opcode.
        applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h0000_0200, 1'b1, 1'b0);
        chk("ill1_flag", 64'(out_illegal), 64'd1);
        chk("ill1_pc", 64'(out_pc), 64'h200);
        chk("ill1_opc", 64'(out_opcode), 64'h7F);
        applyStimulus(1'b1, 32'h4000_1033, 32'h0000_0204, 1'b1, 1'b0);
        chk("ill2_flag_fmt", 64'({out_illegal, out_fmt}), 64'({1'b1, F_N}));
        chk("ill2_imm", 64'(out_imm), 64'd0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Fill with execute stalled; third instruction must wait.
        applyStimulus(1'b1, 32'h0010_0113, 32'h0000_0300, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0020_0193, 32'h0000_0304, 1'b0, 1'b0);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        applyStimulus(1'b1, 32'h0030_0213, 32'h0000_0308, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0030_0213, 32'h0000_0308, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h0030_0213, 32'h0000_0308, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("order_third_pc", 64'(out_pc), 64'h308);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Flush with two entries buffered and a new input offered.
        applyStimulus(1'b1, 32'h0010_0113, 32'h0000_0400, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0020_0193, 32'h0000_0404, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0030_0213, 32'h0000_0408, 1'b1, 1'b1);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);

        // Asynchronous reset mid-stream with two entries buffered.
        applyStimulus(1'b1, 32'h0010_0113, 32'h0000_0500, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0020_0193, 32'h0000_0504, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_dec_count", 64'(dec_count), 64'd0);
        q.delete();
        exp_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput();

        // Randomized traffic; the narrow counter also saturates here.
        pc_next = 32'h0000_1000;
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, rand_instr(), pc_next,
                          $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
            pc_next = pc_next + 32'd4;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered, elastic RV32I decode stage that sits between fetch and execute. It accepts {pc, instruction} over a valid/ready handshake and decodes each instruction into fields, a sign-extended immediate, a format tag and an illegal flag. Results are buffered in a parametrised FIFO and delivered over a second valid/ready handshake. It supports pipeline flush and keeps a saturating count of decoded instructions.

Parameters:
DEPTH, 2, output buffer entries; power of 2, at least 2
CNT_W, 32, width of the decoded-instruction counter
ZERO_UNUSED, 1, 1 = fields not used by the format are driven to 0; 0 = raw instruction bits passed through

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  fetch presents an instruction
in_ready  output  1  stage can accept an instruction
in_pc  input  32  PC of the instruction
in_instr  input  32  raw instruction
flush  input  1  discard all buffered entries and any input this cycle
out_valid  output  1  head entry valid
out_ready  input  1  execute consumes the head entry
out_pc  output  32  PC of the head entry
out_opcode  output  7  instruction[6:0]
out_rd  output  5  destination register
out_rs1  output  5  source register 1
out_rs2  output  5  source register 2 (shamt for immediate shifts)
out_funct3  output  3  funct3
out_funct7  output  7  funct7
out_imm  output  32  sign-extended immediate
out_fmt  output  3  fmt_e: R, I, S, B, U, J, NONE
out_illegal  output  1  instruction is not a supported RV32I op
dec_count  output  CNT_W  number of instructions accepted (saturating)

Behaviour:
- Reset, asynchronous on rst_n low: FIFO empty, out_valid=0, dec_count=0, and all out_* data fields 0 (out_fmt=NONE). in_ready=1 from the first cycle after reset is released.
- Accept: the input is accepted when in_valid & in_ready & !flush. Decode is combinational on the input side; the result is written into the FIFO at the clock edge.
- Latency: with the FIFO empty, out_valid rises 1 cycle after acceptance. There is no combinational path from the input to the output.
- in_ready = !full. Simultaneous push and pop while full is not allowed (in_ready=0), so there is no same-cycle bypass. Simultaneous push and pop otherwise leaves the occupancy unchanged.
- Pop: the head entry is consumed when out_valid & out_ready. The out_* fields are held stable while out_valid=1 and out_ready=0.
- Pointers wrap modulo DEPTH. A count of log2(DEPTH)+1 bits distinguishes full from empty.
- Flush takes priority over push and pop. On the edge where flush=1: the FIFO empties, out_valid=0 next cycle, and no push or pop occurs. The next-cycle in_ready=1.
- dec_count increments on each accept, is not decremented by flush, and saturates at all ones.
- Field extraction:
  - R and OP-IMM (0010011): rd, funct3, rs1, rs2, funct7.
  - LOAD and JALR: rd, funct3, rs1.
  - STORE and BRANCH: funct3, rs1, rs2.
  - LUI, AUIPC, JAL: rd.
  - Unused fields follow the ZERO_UNUSED setting.
- Immediates:
  - I: instr[31:20] sign-extended. For shifts, the immediate is shamt zero-extended.
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R and NONE: 0.
- out_illegal=1 for any of:
  - unknown opcode;
  - R-type with funct7 not 0000000 or 0100000, or funct7=0100000 with funct3 not 000 or 101;
  - SLLI with funct7≠0; SRLI/SRAI with funct7 not 0000000 or 0100000;
  - LOAD with funct3 of 011, 110 or 111;
  - STORE with funct3 > 010;
  - BRANCH with funct3 of 010 or 011;
  - JALR with funct3≠000.
- Illegal instructions are still accepted and delivered with their pc. In that case fields and immediate are 0, out_fmt=NONE, and out_opcode is raw.

Decomposition:
- decode_pkg holds:
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC);
  - fmt_e enum;
  - the packed struct decoded_t {pc, opcode, rd, rs1, rs2, funct3, funct7, imm, fmt, illegal}, which is the FIFO entry type.
- One sub-module, rv32_decode_comb: combinational instruction → decoded_t, including immediate generation and the illegal check.
- The FIFO and handshake logic live in decode_stage.

Test Plan:
- Reset mid-stream with 2 entries buffered → out_valid=0, dec_count=0 immediately, in_ready=1 after release.
- 0x00500093 (ADDI x1,x0,5), out_ready=1 → next cycle out_valid=1, rd=1, rs1=0, funct3=0, imm=0x00000005, fmt=I, illegal=0, dec_count=1.
- Back-to-back 0x0020A423 (SW x2,8(x1)), 0xFFDFF0EF (JAL x1,-4), 0x123452B7 (LUI x5,0x12345) → SW: rs1=1, rs2=2, funct3=010, imm=8, fmt=S. JAL: rd=1, imm=0xFFFFFFFC, fmt=J. LUI: rd=5, imm=0x12345000, fmt=U. All delivered in order, one per cycle.
- 0xFFFFFFFF, then 0x40001033 (funct7=0100000 with funct3=001) → both illegal=1, fmt=NONE, imm=0, pcs preserved.
- DEPTH=2, out_ready=0, three pushes → in_ready=0 after the 2nd accept and the 3rd is held. out_ready=1 for one cycle → head pops, the 3rd is accepted next edge, order is preserved.
- Two entries buffered, flush=1 together with in_valid=1 → next cycle out_valid=0, that input is not accepted, and dec_count is unchanged by the flush.
